// File: rtl/crc_soc_irq_pkg.sv
// Shared constants for the SoC interrupt aggregator: register map, ID width, bus width.
package crc_soc_irq_pkg;

  localparam int MAX_IRQ = 15;
  localparam int ID_W    = 4;
  localparam int DATA_W  = 16;

  localparam logic [2:0] ADDR_PENDING  = 3'd0;
  localparam logic [2:0] ADDR_ENABLE   = 3'd1;
  localparam logic [2:0] ADDR_CURRENT  = 3'd2;
  localparam logic [2:0] ADDR_EOI      = 3'd3;
  localparam logic [2:0] ADDR_RAW      = 3'd4;
  localparam logic [2:0] ADDR_EDGE_SEL = 3'd5;

endpackage

// File: rtl/crc_soc_irq_prio_enc.sv
// Lowest-index-first priority encoder: valid = |req, id = index of lowest set bit.
module crc_soc_irq_prio_enc
  import crc_soc_irq_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]    req,
  output logic            valid,
  output logic [ID_W-1:0] id
);

  // Scan high to low so the lowest set index is the last assignment.
  always_comb begin
    valid = |req;
    id    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) id = ID_W'(i);
    end
  end

endmodule

// File: rtl/crc_soc_irq_ctrl.sv
// Avalon-MM interrupt aggregator: pending/enable registers, single CPU irq, CURRENT id readback.
// Optional edge-triggered sources, EOI and W1C: define CRC_SOC_IRQ_EDGE_EN.
module crc_soc_irq_ctrl
  import crc_soc_irq_pkg::*;
#(
  parameter int NUM_IRQ      = 8,
  parameter int ENABLE_RESET = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq
);

  localparam logic [DATA_W-1:0] EN_RST = DATA_W'(ENABLE_RESET);

  logic               wr;
  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] enable;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] active;
  logic               cur_valid;
  logic [ID_W-1:0]    cur_id;
  logic [DATA_W-1:0]  edge_rd;
  logic [DATA_W-1:0]  rd_mux;
  logic               unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

`ifdef CRC_SOC_IRQ_EDGE_EN
  logic [NUM_IRQ-1:0] irq_qq;
  logic [NUM_IRQ-1:0] edge_sel;
  logic [NUM_IRQ-1:0] pend_e;
  logic [NUM_IRQ-1:0] pend_e_nxt;
  logic [NUM_IRQ-1:0] w1c;
  logic [NUM_IRQ-1:0] eoi;

  // Set term is OR-ed after the clear so a coincident rising edge wins.
  always_comb begin
    w1c = '0;
    eoi = '0;
    if (wr && address == ADDR_PENDING) w1c = writedata[NUM_IRQ-1:0];
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (wr && address == ADDR_EOI && writedata[ID_W-1:0] == ID_W'(i)) eoi[i] = 1'b1;
    end
    pend_e_nxt = ((pend_e & ~(w1c | eoi)) | (irq_q & ~irq_qq)) & edge_sel;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_qq   <= '0;
      edge_sel <= '0;
      pend_e   <= '0;
    end else begin
      irq_qq <= irq_q;
      pend_e <= pend_e_nxt;
      if (wr && address == ADDR_EDGE_SEL) edge_sel <= writedata[NUM_IRQ-1:0];
    end
  end

  assign pending = (pend_e & edge_sel) | (irq_q & ~edge_sel);
  assign edge_rd = DATA_W'(edge_sel);
`else
  assign pending = irq_q;
  assign edge_rd = '0;
`endif

  assign active = pending & enable;

  crc_soc_irq_prio_enc #(.N(NUM_IRQ)) u_prio (
    .req   (active),
    .valid (cur_valid),
    .id    (cur_id)
  );

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_PENDING:  rd_mux = DATA_W'(pending);
      ADDR_ENABLE:   rd_mux = DATA_W'(enable);
      ADDR_CURRENT:  rd_mux = {cur_valid, 11'b0, cur_id};
      ADDR_RAW:      rd_mux = DATA_W'(irq_q);
      ADDR_EDGE_SEL: rd_mux = edge_rd;
      default:       rd_mux = '0;
    endcase
  end

  // readdata is refreshed every cycle, so a same-cycle write is seen on the following read.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q    <= '0;
      enable   <= EN_RST[NUM_IRQ-1:0];
      irq      <= 1'b0;
      readdata <= '0;
    end else begin
      irq_q    <= irq_in;
      irq      <= cur_valid;
      readdata <= rd_mux;
      if (wr && address == ADDR_ENABLE) enable <= writedata[NUM_IRQ-1:0];
    end
  end

endmodule
